// File: rtl/sound_sequencer.sv
// sound_sequencer: plays good/bad/button note sequences; in clk,nRst,goodColl,badColl,button; out tone_en,tone_period,busy,evt
module sound_sequencer #(
  parameter int NOTE_CYCLES = 1200000,
  parameter int GAP_CYCLES  = 120000
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        goodColl,
  input  logic        badColl,
  input  logic        button,
  output logic        tone_en,
  output logic [15:0] tone_period,
  output logic        busy,
  output logic [1:0]  evt
);
  localparam int CMAX = NOTE_CYCLES > GAP_CYCLES ? NOTE_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [1:0] EV_BTN = 2'b01, EV_GOOD = 2'b10, EV_BAD = 2'b11;
  typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;
  state_t state_q, state_d;
  logic idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] evt_q, evt_d;
  logic pend_bad_q, pend_bad_d, pend_good_q, pend_good_d, pend_btn_q, pend_btn_d;
  logic last_idx;
  logic [15:0] note_period;
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q     <= IDLE;
      idx_q       <= 1'b0;
      cnt_q       <= '0;
      evt_q       <= 2'b00;
      pend_bad_q  <= 1'b0;
      pend_good_q <= 1'b0;
      pend_btn_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      evt_q       <= evt_d;
      pend_bad_q  <= pend_bad_d;
      pend_good_q <= pend_good_d;
      pend_btn_q  <= pend_btn_d;
    end
  end
  assign last_idx = (evt_q == EV_BAD || evt_q == EV_GOOD);
  assign note_period = evt_q == EV_BAD  ? (idx_q ? 16'd30000 : 16'd24000) :
                       evt_q == EV_GOOD ? (idx_q ? 16'd6000  : 16'd9000)  :
                       evt_q == EV_BTN  ? 16'd4000 : 16'd0;
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    evt_d       = evt_q;
    pend_bad_d  = pend_bad_q | badColl;
    pend_good_d = pend_good_q | goodColl;
    pend_btn_d  = pend_btn_q | button;
    case (state_q)
      IDLE: begin
        evt_d = pend_bad_d ? EV_BAD : pend_good_d ? EV_GOOD : pend_btn_d ? EV_BTN : 2'b00;
        if (pend_bad_d || pend_good_d || pend_btn_d) begin
          state_d = NOTE;
          idx_d   = 1'b0;
          cnt_d   = '0;
        end
        if (pend_bad_d) pend_bad_d = 1'b0;
        else if (pend_good_d) pend_good_d = 1'b0;
        else if (pend_btn_d) pend_btn_d = 1'b0;
      end
      NOTE: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NOTE_CYCLES - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
        end
      end
      GAP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = (idx_q != last_idx) ? NOTE : IDLE;
          idx_d   = (idx_q != last_idx) ? 1'b1 : 1'b0;
          evt_d   = (idx_q != last_idx) ? evt_q : 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
    // a bad hit preempts lower-priority sequences outright instead of queueing
    if (state_q != IDLE && badColl && evt_q != EV_BAD) begin
      state_d    = NOTE;
      evt_d      = EV_BAD;
      idx_d      = 1'b0;
      cnt_d      = '0;
      pend_bad_d = pend_bad_q;
    end
  end
  assign tone_en     = state_q == NOTE;
  assign tone_period = state_q == NOTE ? note_period : 16'd0;
  assign busy        = state_q != IDLE;
  assign evt         = state_q == IDLE ? 2'b00 : evt_q;
endmodule

// File: tb/tb_sound_sequencer.sv
// tb_sound_sequencer: scoreboard bench for sound_sequencer with NOTE_CYCLES=4, GAP_CYCLES=2
module tb_sound_sequencer;
  typedef struct packed {
    logic        en;
    logic [15:0] per;
    logic        busy;
    logic [1:0]  evt;
  } exp_t;
  logic clk = 1'b0;
  logic nRst = 1'b0;
  logic goodColl = 1'b0, badColl = 1'b0, button = 1'b0;
  logic tone_en, busy;
  logic [15:0] tone_period;
  logic [1:0] evt;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  string tag = "reset";
  sound_sequencer #(.NOTE_CYCLES(4), .GAP_CYCLES(2)) dut (
    .clk(clk), .nRst(nRst), .goodColl(goodColl), .badColl(badColl), .button(button),
    .tone_en(tone_en), .tone_period(tone_period), .busy(busy), .evt(evt)
  );
  always #5 clk = ~clk;
  task automatic push(input logic en, input logic [15:0] per, input logic b, input logic [1:0] ev, input int n);
    for (int i = 0; i < n; i++) q.push_back({en, per, b, ev});
  endtask
  task automatic push_note(input logic [15:0] per, input logic [1:0] ev);
    push(1'b1, per, 1'b1, ev, 4);
  endtask
  task automatic push_gap(input logic [1:0] ev);
    push(1'b0, 16'd0, 1'b1, ev, 2);
  endtask
  task automatic push_idle(input int n);
    push(1'b0, 16'd0, 1'b0, 2'b00, n);
  endtask
  task automatic tick(input logic g, input logic bd, input logic bt, input logic r);
    exp_t o, e;
    goodColl = g;
    badColl  = bd;
    button   = bt;
    nRst     = r;
    @(posedge clk);
    #1;
    goodColl = 1'b0;
    badColl  = 1'b0;
    button   = 1'b0;
    nRst     = 1'b1;
    cyc++;
    o = {tone_en, tone_period, busy, evt};
    checks++;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL %s cyc %0d: scoreboard empty, observed en=%b per=%0d busy=%b evt=%b", tag, cyc, o.en, o.per, o.busy, o.evt);
    end else begin
      e = q.pop_front();
      assert (o === e) else begin
        errors++;
        $error("FAIL %s cyc %0d: observed en=%b per=%0d busy=%b evt=%b expected en=%b per=%0d busy=%b evt=%b",
               tag, cyc, o.en, o.per, o.busy, o.evt, e.en, e.per, e.busy, e.evt);
      end
    end
    checks++;
    assert (!(tone_en === 1'b1 && tone_period === 16'd0)) else begin
      errors++;
      $error("FAIL %s cyc %0d: tone_en=%b with period %0d, expected nonzero period", tag, cyc, tone_en, tone_period);
    end
  endtask
  task automatic push_good_seq();
    push_note(16'd9000, 2'b10); push_gap(2'b10); push_note(16'd6000, 2'b10); push_gap(2'b10);
  endtask
  task automatic push_bad_seq();
    push_note(16'd24000, 2'b11); push_gap(2'b11); push_note(16'd30000, 2'b11); push_gap(2'b11);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    checks++;
    assert ({tone_en, tone_period, busy, evt} === 20'd0) else begin
      errors++;
      $error("FAIL reset: observed en=%b per=%0d busy=%b evt=%b expected all zero", tone_en, tone_period, busy, evt);
    end
    nRst = 1'b1;
    tag = "quiet";
    push_idle(100);
    for (int i = 0; i < 100; i++) tick(1'b0, 1'b0, 1'b0, 1'b1);
    tag = "good_seq";
    cyc = 0;
    push_good_seq(); push_idle(1);
    for (int i = 0; i < 13; i++) tick(i == 0, 1'b0, 1'b0, 1'b1);
    tag = "good_and_btn";
    cyc = 0;
    push_good_seq(); push_idle(1); push_note(16'd4000, 2'b01); push_gap(2'b01); push_idle(2);
    for (int i = 0; i < 21; i++) tick(i == 0, 1'b0, i == 0, 1'b1);
    tag = "bad_abort";
    cyc = 0;
    push(1'b1, 16'd4000, 1'b1, 2'b01, 2); push_bad_seq(); push_idle(5);
    for (int i = 0; i < 19; i++) tick(1'b0, i == 2, i == 0, 1'b1);
    tag = "bad_twice";
    cyc = 0;
    push_bad_seq(); push_idle(1); push_bad_seq(); push_idle(3);
    for (int i = 0; i < 28; i++) tick(1'b0, i == 0 || i == 3 || i == 5, 1'b0, 1'b1);
    tag = "good_pend_in_bad";
    cyc = 0;
    push_bad_seq(); push_idle(1); push_good_seq(); push_idle(2);
    for (int i = 0; i < 27; i++) tick(i == 4 || i == 9, i == 0, 1'b0, 1'b1);
    tag = "reset_mid";
    cyc = 0;
    push_note(16'd9000, 2'b10); push_gap(2'b10); push(1'b1, 16'd6000, 1'b1, 2'b10, 2); push_idle(12);
    for (int i = 0; i < 20; i++) tick(i == 0 || i == 8, 1'b0, i == 3 || i == 8, i != 8);
    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL drain: observed %0d leftover entries, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sound_sequencer.md
SOUND_SEQUENCER -- requirements
Module: sound_sequencer

Interface
REQ-001 SHALL have parameter NOTE_CYCLES, default 1200000, meaning clock cycles each note is held (>=2).
REQ-002 SHALL have parameter GAP_CYCLES, default 120000, meaning silent cycles after each note (>=1).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port nRst  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port goodColl  input  1  single-cycle good-collision event pulse.
REQ-006 SHALL have port badColl  input  1  single-cycle bad-collision event pulse.
REQ-007 SHALL have port button  input  1  single-cycle button event pulse.
REQ-008 SHALL have port tone_en  output  1  tone generator enable.
REQ-009 SHALL have port tone_period  output  16  half-period in cycles for the tone generator.
REQ-010 SHALL have port busy  output  1  sequence in progress.
REQ-011 SHALL have port evt  output  2  event playing: 00 none, 01 button, 10 good, 11 bad.

Function
REQ-012 SHALL use states IDLE, NOTE, GAP; a note index register (0..1); a cycle counter wide enough for max(NOTE_CYCLES, GAP_CYCLES).
REQ-013 SHALL use fixed note tables: bad = {24000, 30000}, good = {9000, 6000}, button = {4000} (one note).
REQ-014 SHALL keep pending flags pend_bad, pend_good, pend_btn; each flag is set by its input pulse and cleared when its sequence launches.
REQ-015 SHALL launch from IDLE on (pending flag OR same-cycle input pulse), priority bad > good > button; NOTE is entered next cycle (1-cycle latency pulse -> tone_en).
REQ-016 SHALL, on launch, load note index 0 and counter 0, set evt, and clear only the launched event's pending flag; a same-cycle pulse for the launched event is absorbed (no replay).
REQ-017 SHALL, in NOTE, drive tone_en=1 and tone_period=table[evt][index]; after NOTE_CYCLES cycles go to GAP with counter reset.
REQ-018 SHALL, in GAP, drive tone_en=0 and tone_period=0; after GAP_CYCLES cycles go to NOTE with index+1 if more notes remain, else go to IDLE.
REQ-019 SHALL return through one IDLE cycle between sequences; queued pending events launch from that cycle by priority.
REQ-020 SHALL, on badColl while evt is 01 or 10, abort the current sequence and enter NOTE of bad index 0 next cycle; the aborted event is dropped, pend_bad not set.
REQ-021 SHALL, on badColl while evt=11, set pend_bad (bad replays once after current sequence); repeated pulses while pending collapse to one.
REQ-022 SHALL, on goodColl or button during any sequence, only set the corresponding pending flag.
REQ-023 SHALL drive busy=1 in NOTE and GAP, 0 in IDLE; evt=00 in IDLE.
REQ-024 SHALL never emit tone_en=1 with tone_period=0.

Reset
REQ-025 SHALL, while nRst=0 at a clock edge, force state IDLE, index 0, counter 0, all pending flags 0, tone_en=0, tone_period=0, busy=0, evt=00.
REQ-026 SHALL let reset abort any sequence mid-note; input pulses in the reset cycle are ignored.

Verification (NOTE_CYCLES=4, GAP_CYCLES=2)
REQ-027 SHALL cover: goodColl pulse at cycle 0 -> tone_en=1, period 9000, cycles 1-4; off 5-6; period 6000, cycles 7-10; off 11-12; busy=0, evt=00 at 13.
REQ-028 SHALL cover: goodColl and button same cycle -> good sequence plays, then one IDLE cycle, then button note period 4000 for 4 cycles, evt=01.
REQ-029 SHALL cover: button at cycle 0, badColl at cycle 2 -> period 24000 from cycle 3, evt=11; no button replay afterwards.
REQ-030 SHALL cover: badColl at cycle 0 and again at cycles 3 and 5 -> bad sequence plays exactly twice, separated by one IDLE cycle.
REQ-031 SHALL cover: nRst=0 during second note of good sequence -> next cycle all outputs 0, no pending replay after release.
REQ-032 SHALL cover: no input pulses for 100 cycles after reset -> tone_en=0, busy=0 throughout.
